// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. The operand is split into
// BLOCK_W-bit lookahead groups; GPS groups form one pipeline stage, and the
// carry is registered between stages so the clock rate does not depend on
// WIDTH. Full valid/ready backpressure: one shared enable stalls every stage.

module cla_stage #(
  parameter int BLOCK_W = 4,
  parameter int GPS     = 2
) (
  input  logic [BLOCK_W*GPS-1:0] a,
  input  logic [BLOCK_W*GPS-1:0] b,
  input  logic                   ci,
  input  logic                   p_in,
  input  logic                   g_in,
  output logic [BLOCK_W*GPS-1:0] s,
  output logic                   co,
  output logic                   p_out,
  output logic                   g_out
);
  localparam int S = BLOCK_W * GPS;

  logic [S-1:0]   pb, gb, cb;
  logic [GPS:0]   gc;
  logic [GPS-1:0] gp, gg;
  logic           sg;

  assign pb = a ^ b;
  assign gb = a & b;

  // Carry into bit n of a group, written as the flat lookahead sum of
  // products (no ripple): c_n = c*p0..p(n-1) | sum_k g_k*p(k+1)..p(n-1).
  function automatic logic la_carry(input logic [BLOCK_W-1:0] prop,
                                    input logic [BLOCK_W-1:0] gen,
                                    input logic c, input int n);
    logic r, t;
    r = c;
    for (int k = 0; k < BLOCK_W; k++)
      if (k < n) r = r & prop[k];
    for (int k = 0; k < BLOCK_W; k++) begin
      t = gen[k];
      for (int m = 0; m < BLOCK_W; m++)
        if (m > k && m < n) t = t & prop[m];
      if (k < n) r = r | t;
    end
    return r;
  endfunction

  // Per-group lookahead carries; groups chain through their group P/G.
  always_comb begin
    gc = '0;
    gp = '0;
    gg = '0;
    cb = '0;
    gc[0] = ci;
    for (int j = 0; j < GPS; j++) begin
      for (int i = 0; i < BLOCK_W; i++)
        cb[j*BLOCK_W+i] = la_carry(pb[j*BLOCK_W +: BLOCK_W], gb[j*BLOCK_W +: BLOCK_W], gc[j], i);
      gp[j]   = &pb[j*BLOCK_W +: BLOCK_W];
      gg[j]   = la_carry(pb[j*BLOCK_W +: BLOCK_W], gb[j*BLOCK_W +: BLOCK_W], 1'b0, BLOCK_W);
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
  end

  // Stage-level generate composed from group P/G, independent of carry-in.
  always_comb begin
    sg = 1'b0;
    for (int j = 0; j < GPS; j++)
      sg = gg[j] | (gp[j] & sg);
  end

  assign s     = pb ^ cb;
  assign co    = gc[GPS];
  // This stage is more significant than everything folded in so far.
  assign p_out = p_in & (&gp);
  assign g_out = sg | ((&gp) & g_in);
endmodule

module pipelined_cla_adder #(
  parameter int WIDTH   = 32,
  parameter int BLOCK_W = 4,
  parameter int GPS     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             p,
  output logic             g
);
  localparam int S       = BLOCK_W * GPS;
  localparam int NSTAGES = WIDTH / S;
  localparam int L       = NSTAGES - 1;

  if (WIDTH % S != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK_W*GPS");
  end

  logic en;
  logic ovf_nxt, ovf_r;

  for (genvar k = 0; k < NSTAGES; k++) begin : stg
    // Operand bits not yet consumed (this stage's slice and above).
    logic [WIDTH-1:k*S]   opa, opb;
    logic                 cy, wp, wg, vl;
    logic [S-1:0]         slice;
    logic                 cy_nxt, wp_nxt, wg_nxt;
    logic [(k+1)*S-1:0]   sum_nxt, sum_r;
    logic                 cy_r, wp_r, wg_r, vld_r;

    if (k == 0) begin : g_head
      assign opa     = a;
      assign opb     = b ^ {WIDTH{sub}};
      assign cy      = sub | cin;
      assign wp      = 1'b1;
      assign wg      = 1'b0;
      assign vl      = in_valid;
      assign sum_nxt = slice;
    end else begin : g_body
      assign opa     = stg[k-1].g_fwd.opa_r;
      assign opb     = stg[k-1].g_fwd.opb_r;
      assign cy      = stg[k-1].cy_r;
      assign wp      = stg[k-1].wp_r;
      assign wg      = stg[k-1].wg_r;
      assign vl      = stg[k-1].vld_r;
      assign sum_nxt = {slice, stg[k-1].sum_r};
    end

    cla_stage #(.BLOCK_W(BLOCK_W), .GPS(GPS)) u_cla (
      .a    (opa[k*S +: S]),
      .b    (opb[k*S +: S]),
      .ci   (cy),
      .p_in (wp),
      .g_in (wg),
      .s    (slice),
      .co   (cy_nxt),
      .p_out(wp_nxt),
      .g_out(wg_nxt)
    );

    // Stage register: sum skew, carry, running P/G and valid advance together.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= 1'b0;
        sum_r <= '0;
        cy_r  <= 1'b0;
        wp_r  <= 1'b0;
        wg_r  <= 1'b0;
      end else if (en) begin
        vld_r <= vl;
        sum_r <= sum_nxt;
        cy_r  <= cy_nxt;
        wp_r  <= wp_nxt;
        wg_r  <= wg_nxt;
      end
    end

    if (k < L) begin : g_fwd
      logic [WIDTH-1:(k+1)*S] opa_r, opb_r;
      // Forward the unprocessed upper operand bits (MSBs ride along for ovf).
      always_ff @(posedge clk) begin
        if (rst) begin
          opa_r <= '0;
          opb_r <= '0;
        end else if (en) begin
          opa_r <= opa[WIDTH-1:(k+1)*S];
          opb_r <= opb[WIDTH-1:(k+1)*S];
        end
      end
    end
  end

  assign ovf_nxt = (stg[L].opa[WIDTH-1] == stg[L].opb[WIDTH-1]) &&
                   (stg[L].slice[S-1] != stg[L].opa[WIDTH-1]);

  // Overflow is resolved in the final stage and registered alongside the sum.
  always_ff @(posedge clk) begin
    if (rst)     ovf_r <= 1'b0;
    else if (en) ovf_r <= ovf_nxt;
  end

  assign out_valid = stg[L].vld_r;
  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign sum       = stg[L].sum_r;
  assign cout      = stg[L].cy_r;
  assign p         = stg[L].wp_r;
  assign g         = stg[L].wg_r;
  assign ovf       = ovf_r;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed test-plan vectors plus a random
// stream with random backpressure, scoreboarded against an arithmetic model.
module tb_pipelined_cla_adder;
  localparam int W   = 32;
  localparam int NST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic         cout, ovf, p, g;
  logic [W-1:0] a, b, sum;

  logic         in_valid16, in_ready16, out_valid16, cout16, ovf16, p16, g16;
  logic [15:0]  a16, b16, sum16;

  pipelined_cla_adder #(.WIDTH(32), .BLOCK_W(4), .GPS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .p(p), .g(g));

  pipelined_cla_adder #(.WIDTH(16), .BLOCK_W(4), .GPS(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(1'b0), .sub(1'b0), .out_valid(out_valid16),
    .out_ready(1'b1), .sum(sum16), .cout(cout16), .ovf(ovf16), .p(p16), .g(g16));

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         p;
    logic         g;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t expq[$];
  int   emit_cyc[$];
  logic emit_ovf[$];
  res_t cur, held;
  logic hold_v = 1'b0;

  assign cur = {sum, cout, ovf, p, g};

  // Reference: plain wide arithmetic on the effective operands.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    logic [W-1:0] yb;
    logic [W:0]   full, gen;
    res_t         r;
    yb    = s ? ~y : y;
    full  = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, (s ? 1'b1 : c)};
    gen   = {1'b0, x} + {1'b0, yb};
    r.sum = full[W-1:0];
    r.cout = full[W];
    r.ovf = (x[W-1] == yb[W-1]) && (r.sum[W-1] != x[W-1]);
    r.p   = &(x ^ yb);
    r.g   = gen[W];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: outputs and handshakes sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("stall_hold", {out_valid, cur}, {1'b1, held});
      hold_v = out_valid && !out_ready;
      held   = cur;
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          chk("data", cur, expq.pop_front());
          emit_cyc.push_back(cyc);
          emit_ovf.push_back(ovf);
        end
      end
      if (in_valid && in_ready) expq.push_back(model(a, b, cin, sub));
    end
  end

  // Present a beat at posedge+1 and hold it until accepted.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    int n;
    n = 0;
    in_valid = 1'b1; a = x; b = y; cin = c; sub = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Single beat into an idle pipe; lat counts edges from accept to valid.
  task automatic run1(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input logic s, output res_t r, output int lat);
    in_valid = 1'b1; a = x; b = y; cin = c; sub = s;
    chk("run1_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r = cur;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   lat;
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; in_valid16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_flags", {cout, ovf, p, g}, 4'b0000);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Full carry chain through every stage.
    run1(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, r, lat);
    chk("carry_chain", r, {32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    chk("carry_chain_lat", lat, NST);

    run1(32'h5, 32'h7, 1'b0, 1'b1, r, lat);
    chk("sub_neg", {r.sum, r.cout, r.ovf}, {32'hFFFF_FFFE, 1'b0, 1'b0});
    run1(32'h8000_0000, 32'h1, 1'b0, 1'b1, r, lat);
    chk("sub_ovf", {r.sum, r.cout, r.ovf}, {32'h7FFF_FFFF, 1'b1, 1'b1});
    run1(32'h9, 32'h9, 1'b1, 1'b1, r, lat);
    chk("sub_cin_ignored", {r.sum, r.cout}, {32'h0, 1'b1});
    @(posedge clk); #1;

    // Eight back-to-back beats.
    emit_cyc.delete(); emit_ovf.delete();
    for (int i = 0; i < 8; i++) send(W'(i), 32'h7FFF_FFFF, i[0], 1'b0);
    in_valid = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("stream_count", emit_cyc.size(), 8);
    if (emit_cyc.size() == 8) begin
      chk("stream_b2b", emit_cyc[7] - emit_cyc[0], 7);
      for (int i = 0; i < 8; i++) chk("stream_ovf", emit_ovf[i], (i != 0));
    end

    // Fill, then stall the sink for 3 cycles with a new beat waiting.
    for (int i = 0; i < 4; i++) send(rnd_word(), rnd_word(), 1'(i), 1'b0);
    ra = rnd_word(); rb = rnd_word();
    in_valid = 1'b1; a = ra; b = rb; cin = 1'b1; sub = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(ra, rb, 1'b1, 1'b1);
    in_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("stall_drain", expq.size(), 0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(rnd_word(), rnd_word(), 1'($urandom), 1'($urandom));
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    emit_cyc.delete();
    @(negedge clk);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_sum", sum, '0);
    repeat (10) @(posedge clk); #1;
    chk("flush_no_emit", emit_cyc.size(), 0);
    ra = rnd_word(); rb = rnd_word();
    run1(ra, rb, 1'b1, 1'b0, r, lat);
    chk("post_rst_data", r, model(ra, rb, 1'b1, 1'b0));
    chk("post_rst_lat", lat, NST);
    @(posedge clk); #1;

    // Random traffic under random backpressure.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 2) != 0) send(rnd_word(), rnd_word(), 1'($urandom), 1'($urandom));
          else begin in_valid = 1'b0; @(posedge clk); #1; end
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 300; i++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("random_drain", expq.size(), 0);

    // 16-bit, one group per stage.
    a16 = 16'h7FFF; b16 = 16'h0001; in_valid16 = 1'b1;
    chk("w16_ready", in_ready16, 1'b1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("w16_sum", sum16, 16'h8000);
    chk("w16_flags", {cout16, ovf16, p16, g16}, 4'b0100);
    chk("w16_lat", lat, NST);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
